msg_serializer: RTL and testbench



---
 rtl/msg_serializer_if.sv | 28 ++
 rtl/msg_serializer.sv | 90 +++++++++
 tb/tb_msg_serializer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_serializer_if.sv
// Handshake bundle for msg_serializer: wide message in, narrow beats out.
// master = producer/consumer side, slave = serializer side.
interface msg_serializer_if #(
  parameter int p_msg_nbits  = 32,
  parameter int p_beat_nbits = 8
);
  localparam int c_num_beats = p_msg_nbits / p_beat_nbits;
  localparam int c_cnt_nbits = $clog2(c_num_beats);

  logic                    in_val;
  logic                    in_rdy;
  logic [p_msg_nbits-1:0]  in_msg;
  logic                    out_val;
  logic                    out_rdy;
  logic [p_beat_nbits-1:0] out_msg;
  logic                    out_last;
  logic [c_cnt_nbits-1:0]  beat_idx;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_last, beat_idx
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_last, beat_idx
  );
endinterface

// File: rtl/msg_serializer.sv
// Width-down val/rdy serializer: registers one wide message, emits it LSB slice first.
// Define MSG_SERIALIZER_PIPE_EN to accept the next message on the last-beat transfer.
module msg_serializer #(
  parameter int p_msg_nbits  = 32,
  parameter int p_beat_nbits = 8
) (
  input  logic           clk,
  input  logic           reset,
  msg_serializer_if.slave bus
);
  localparam int c_num_beats = p_msg_nbits / p_beat_nbits;
  localparam int c_cnt_nbits = $clog2(c_num_beats);
  localparam logic [c_cnt_nbits-1:0] c_last_idx = c_cnt_nbits'(c_num_beats - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                   state;
  state_t                                   state_next;
  logic [p_msg_nbits-1:0]                   msg_reg;
  logic [c_cnt_nbits-1:0]                   idx;
  logic [c_cnt_nbits-1:0]                   idx_next;
  logic                                     load;
  logic                                     last;
  logic [c_num_beats-1:0][p_beat_nbits-1:0] slices;

  assign slices = msg_reg;
  assign last   = (state == SEND) && (idx == c_last_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      msg_reg <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load) msg_reg <= bus.in_msg;
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    load         = 1'b0;
    bus.in_rdy   = 1'b0;
    bus.out_val  = 1'b0;
    bus.out_last = 1'b0;
    bus.beat_idx = '0;
    bus.out_msg  = slices[idx];
    case (state)
      IDLE: begin
        bus.in_rdy = 1'b1;
        if (bus.in_val) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        bus.out_val  = 1'b1;
        bus.out_last = last;
        bus.beat_idx = idx;
`ifdef MSG_SERIALIZER_PIPE_EN
        // Combinational out_rdy -> in_rdy: refill on the last-beat transfer.
        bus.in_rdy = bus.out_rdy && last;
`endif
        if (bus.out_rdy) begin
          if (last) begin
            idx_next   = '0;
            state_next = IDLE;
`ifdef MSG_SERIALIZER_PIPE_EN
            if (bus.in_val) begin
              load       = 1'b1;
              state_next = SEND;
            end
`endif
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset overrides the handshake outputs regardless of inputs.
    if (reset) begin
      bus.in_rdy  = 1'b0;
      bus.out_val = 1'b0;
    end
  end
endmodule

// File: tb/tb_msg_serializer.sv
// Self-checking bench for msg_serializer (32-bit messages, 8-bit beats).
// Build with +define+MSG_SERIALIZER_PIPE_EN to check the pipelined variant.
module tb_msg_serializer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] q[$];  // {beat_idx, last, byte}

  always #5 clk = ~clk;

  msg_serializer_if bus ();

  msg_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MSG_SERIALIZER_PIPE_EN
  localparam bit pipe = 1'b1;
`else
  localparam bit pipe = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_val = 1'b1;
    bus.in_msg = 32'h12345678;
    bus.out_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks += 2;
      if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %b want 0", bus.in_rdy); end
      if (bus.out_val !== 1'b0) begin errors++; $display("FAIL rst_out_val got %b want 0", bus.out_val); end
      cyc();
    end
    reset = 1'b0;
    bus.in_val = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_in_rdy got %b want 1", bus.in_rdy); end
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL post_rst_out_val got %b want 0", bus.out_val); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL post_rst_last got %b want 0", bus.out_last); end
    if (bus.beat_idx !== 2'd0) begin errors++; $display("FAIL post_rst_idx got %0d want 0", bus.beat_idx); end
    if (bus.out_msg !== 8'h00) begin errors++; $display("FAIL post_rst_nocapture got %h want 00", bus.out_msg); end
    cyc();
  endtask

  task automatic test_single();
    logic [31:0] m;
    logic        exp_rdy;
    m = 32'hDDCCBBAA;
    bus.in_val = 1'b1;
    bus.in_msg = m;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", bus.in_rdy); end
    cyc();
    bus.in_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_rdy = pipe && (k == 3);
      checks += 5;
      if (bus.out_val !== 1'b1) begin errors++; $display("FAIL single_val[%0d] got %b want 1", k, bus.out_val); end
      if (bus.out_msg !== m[k*8 +: 8]) begin errors++; $display("FAIL single_msg[%0d] got %h want %h", k, bus.out_msg, m[k*8 +: 8]); end
      if (bus.out_last !== 1'(k == 3)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", k, bus.out_last, k == 3); end
      if (bus.beat_idx !== 2'(k)) begin errors++; $display("FAIL single_idx[%0d] got %0d want %0d", k, bus.beat_idx, k); end
      if (bus.in_rdy !== exp_rdy) begin errors++; $display("FAIL single_in_rdy[%0d] got %b want %b", k, bus.in_rdy, exp_rdy); end
      cyc();
    end
    @(negedge clk);
    checks += 2;
    if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL single_done_rdy got %b want 1", bus.in_rdy); end
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL single_done_val got %b want 0", bus.out_val); end
    cyc();
  endtask

  task automatic test_backpressure();
    bus.in_val = 1'b1;
    bus.in_msg = 32'hDDCCBBAA;
    bus.out_rdy = 1'b1;
    cyc();
    bus.in_val = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_msg !== 8'hAA) begin errors++; $display("FAIL bp_first got %h want aa", bus.out_msg); end
    cyc();
    bus.out_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (bus.out_msg !== 8'hBB) begin errors++; $display("FAIL bp_hold_msg got %h want bb", bus.out_msg); end
      if (bus.beat_idx !== 2'd1) begin errors++; $display("FAIL bp_hold_idx got %0d want 1", bus.beat_idx); end
      if (bus.out_val !== 1'b1) begin errors++; $display("FAIL bp_hold_val got %b want 1", bus.out_val); end
      cyc();
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_msg !== 8'hBB) begin errors++; $display("FAIL bp_release got %h want bb", bus.out_msg); end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.out_msg !== 8'hCC) begin errors++; $display("FAIL bp_resume got %h want cc", bus.out_msg); end
    cyc();
    @(negedge clk);
    checks += 2;
    if (bus.out_msg !== 8'hDD) begin errors++; $display("FAIL bp_tail got %h want dd", bus.out_msg); end
    if (bus.out_last !== 1'b1) begin errors++; $display("FAIL bp_tail_last got %b want 1", bus.out_last); end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", bus.out_val); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] msgs [2];
    logic [10:0] e;
    int sent, nout, t44, t55, tlast, n;
    msgs[0] = 32'h44332211;
    msgs[1] = 32'h88776655;
    sent = 0; nout = 0; t44 = -1; t55 = -1; tlast = -1; n = 0;
    q.delete();
    bus.out_rdy = 1'b1;
    while (n < 40 && (sent < 2 || q.size() > 0)) begin
      bus.in_val = (sent < 2);
      bus.in_msg = (sent < 2) ? msgs[sent] : 32'h0;
      @(negedge clk);
      if (bus.out_val && bus.out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got %h want none", bus.out_msg);
        end else begin
          e = q.pop_front();
          if ({bus.beat_idx, bus.out_last, bus.out_msg} !== e) begin
            errors++; $display("FAIL b2b_beat got %h want %h", {bus.beat_idx, bus.out_last, bus.out_msg}, e);
          end
        end
        if (nout == 3) t44 = n;
        if (nout == 4) t55 = n;
        tlast = n;
        nout++;
      end
      if (bus.in_val && bus.in_rdy) begin
        for (int k = 0; k < 4; k++) q.push_back({2'(k), 1'(k == 3), bus.in_msg[k*8 +: 8]});
        sent++;
      end
      cyc();
      n++;
    end
    bus.in_val = 1'b0;
    checks += 4;
    if (sent != 2 || q.size() != 0) begin errors++; $display("FAIL b2b_timeout got sent=%0d left=%0d want 2/0", sent, q.size()); end
    if (nout != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", nout); end
    if (tlast != (pipe ? 8 : 9)) begin errors++; $display("FAIL b2b_final_cycle got %0d want %0d", tlast, pipe ? 8 : 9); end
    if (t55 - t44 != (pipe ? 1 : 2)) begin errors++; $display("FAIL b2b_gap got %0d want %0d", t55 - t44, pipe ? 1 : 2); end
  endtask

  task automatic test_reset_mid();
    bus.in_val = 1'b1;
    bus.in_msg = 32'hDDCCBBAA;
    bus.out_rdy = 1'b1;
    cyc();
    bus.in_val = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL mid_rst_val got %b want 0", bus.out_val); end
    if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy got %b want 0", bus.in_rdy); end
    cyc();
    reset = 1'b0;
    bus.in_val = 1'b1;
    bus.in_msg = 32'h04030201;
    @(negedge clk);
    checks += 2;
    if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL mid_after_rdy got %b want 1", bus.in_rdy); end
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL mid_after_val got %b want 0", bus.out_val); end
    cyc();
    bus.in_val = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.out_val !== 1'b1) begin errors++; $display("FAIL mid_next_val got %b want 1", bus.out_val); end
    if (bus.out_msg !== 8'h01) begin errors++; $display("FAIL mid_next_msg got %h want 01", bus.out_msg); end
    if (bus.beat_idx !== 2'd0) begin errors++; $display("FAIL mid_next_idx got %0d want 0", bus.beat_idx); end
    repeat (4) cyc();
  endtask

  task automatic test_random();
    logic [10:0] e;
    logic        prev_stall;
    logic [7:0]  prev_msg;
    logic [1:0]  prev_idx;
    int sent, lasts, n;
    sent = 0; lasts = 0; n = 0;
    prev_stall = 1'b0; prev_msg = '0; prev_idx = '0;
    q.delete();
    while ((sent < 200 || q.size() > 0) && n < 20000) begin
      bus.in_val = (sent < 200) && ($urandom_range(0, 9) < 7);
      bus.in_msg = $urandom;
      bus.out_rdy = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!bus.out_val || bus.out_msg !== prev_msg || bus.beat_idx !== prev_idx) begin
          errors++; $display("FAIL rnd_stall_hold got %b/%h/%0d want 1/%h/%0d", bus.out_val, bus.out_msg, bus.beat_idx, prev_msg, prev_idx);
        end
      end
      if (bus.out_val && bus.out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got %h want none", bus.out_msg);
        end else begin
          e = q.pop_front();
          if ({bus.beat_idx, bus.out_last, bus.out_msg} !== e) begin
            errors++; $display("FAIL rnd_beat got %h want %h", {bus.beat_idx, bus.out_last, bus.out_msg}, e);
          end
        end
        if (bus.out_last) lasts++;
      end
      if (bus.in_val && bus.in_rdy) begin
        for (int k = 0; k < 4; k++) q.push_back({2'(k), 1'(k == 3), bus.in_msg[k*8 +: 8]});
        sent++;
      end
      prev_stall = bus.out_val && !bus.out_rdy;
      prev_msg = bus.out_msg;
      prev_idx = bus.beat_idx;
      cyc();
      n++;
    end
    bus.in_val = 1'b0;
    bus.out_rdy = 1'b1;
    checks += 2;
    if (sent != 200 || q.size() != 0) begin errors++; $display("FAIL rnd_timeout got sent=%0d left=%0d want 200/0", sent, q.size()); end
    if (lasts != 200) begin errors++; $display("FAIL rnd_last_count got %0d want 200", lasts); end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_val = 1'b0;
    bus.in_msg = '0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
